// File: rtl/simon_playback_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_playback_seq_if
// Brief    : Bundles the timebase, game-FSM handshake, sequence-memory read
//            port and LED drive of the Simon playback sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface simon_playback_seq_if #(
    parameter int SEQ_AW = 4
);
    logic              tick;
    logic              start;
    logic              abort;
    logic [SEQ_AW:0]   len;
    logic              rd_en;
    logic [SEQ_AW-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic [3:0]        led;
    logic              busy;
    logic              done;

    // Environment side: game FSM, clock divider and sequence memory.
    modport master (
        output tick, start, abort, len, rd_data,
        input  rd_en, rd_addr, led, busy, done
    );

    modport slave (
        input  tick, start, abort, len, rd_data,
        output rd_en, rd_addr, led, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/simon_playback_seq.sv
`default_nettype none
// ============================================================================
// Module   : simon_playback_seq
// Brief    : Plays back the first len entries of the Simon sequence memory,
//            flashing one LED per entry followed by a dark gap.
// Revision : 1.0 - initial release
// ============================================================================
module simon_playback_seq #(
    parameter int SEQ_AW    = 4,
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    simon_playback_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ON    = 3'd3,
        S_OFF   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0]      c_ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0]      c_OFF_LAST = 8'(OFF_TICKS - 1);
    localparam logic [SEQ_AW:0] c_ONE      = (SEQ_AW+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    // One bit wider than the address so a full-depth run ends without wrapping.
    logic [SEQ_AW:0]   r_idx;
    logic [SEQ_AW:0]   w_idx_nxt;
    logic [SEQ_AW:0]   r_len;
    logic [SEQ_AW:0]   w_len_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [1:0]        r_data;
    logic [1:0]        w_data_nxt;
    logic [3:0]        r_led;
    logic [3:0]        w_led_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_led   <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_led_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_len_nxt   = bus.len;
                    w_idx_nxt   = '0;
                    w_state_nxt = (bus.len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                // LED register loads straight from memory so it lights on ON entry.
                w_data_nxt  = bus.rd_data;
                w_cnt_nxt   = '0;
                w_led_nxt   = 4'b0001 << bus.rd_data;
                w_state_nxt = S_ON;
            end
            S_ON: begin
                w_led_nxt = 4'b0001 << r_data;
                if (bus.tick) begin
                    if (r_cnt == c_ON_LAST) begin
                        w_cnt_nxt   = '0;
                        w_led_nxt   = '0;
                        w_state_nxt = S_OFF;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_OFF: begin
                if (bus.tick) begin
                    if (r_cnt == c_OFF_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_idx == r_len - c_ONE) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + c_ONE;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_led_nxt   = '0;
            w_cnt_nxt   = '0;
        end
    end

    assign bus.rd_en   = (r_state == S_FETCH);
    assign bus.rd_addr = r_idx[SEQ_AW-1:0];
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.led     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_simon_playback_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_playback_seq
// Brief    : Directed self-checking bench for simon_playback_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_playback_seq;

    localparam int SEQ_AW = 4;
    localparam int ON_T   = 3;
    localparam int OFF_T  = 2;
    localparam int P      = 2 + ON_T + OFF_T;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    simon_playback_seq_if #(.SEQ_AW(SEQ_AW)) bus();

    simon_playback_seq #(
        .SEQ_AW    (SEQ_AW),
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Sequence memory: synchronous read, one-cycle latency.
    logic [1:0] mem [16];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int total = 0;
    int bad   = 0;

    logic [3:0]        q_led  [$];
    logic [SEQ_AW-1:0] q_addr [$];
    logic [3:0]        prev_led;
    int done_cnt, done_cyc, lit_cnt, first_lit, last_lit, extra_rd, extra_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int n);
        q_led.delete();
        q_addr.delete();
        for (int i = 0; i < n; i++) begin
            q_led.push_back(4'b0001 << mem[i]);
            q_addr.push_back(i[SEQ_AW-1:0]);
        end
    endtask

    // Start a run and observe ncyc cycles after the accepting edge.
    task automatic play(input int len, input int ncyc, input int tper,
                        input int abort_at, input int restart_at, input bit timeline);
        int i, ph;
        logic [3:0] el;
        logic er, eb, ed;
        done_cnt = 0; done_cyc = 0; lit_cnt = 0; first_lit = 0; last_lit = 0;
        extra_rd = 0; extra_fl = 0; prev_led = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = (SEQ_AW+1)'(len);
        bus.tick  = (tper == 1);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (bus.rd_en) begin
                if (q_addr.size() == 0) extra_rd++;
                else chk("rd_addr_sb", 32'(bus.rd_addr), 32'(q_addr.pop_front()));
            end
            if (bus.led != 4'd0 && prev_led == 4'd0) begin
                if (q_led.size() == 0) extra_fl++;
                else chk("flash_sb", 32'(bus.led), 32'(q_led.pop_front()));
            end
            if (bus.led != 4'd0) begin
                lit_cnt++;
                if (first_lit == 0) first_lit = c;
                last_lit = c;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            prev_led = bus.led;
            chk("led_onehot0", 32'($onehot0(bus.led)), 32'd1);
            if (abort_at != 0 && c == abort_at + 1) begin
                chk("abort_led", 32'(bus.led), 32'd0);
                chk("abort_busy", 32'(bus.busy), 32'd0);
            end
            if (timeline) begin
                if (c <= P * len) begin
                    i  = (c - 1) / P;
                    ph = (c - 1) % P;
                    er = (ph == 0);
                    eb = 1'b1;
                    ed = 1'b0;
                    el = (ph >= 2 && ph < 2 + ON_T) ? (4'b0001 << mem[i]) : 4'd0;
                end else begin
                    i  = 0;
                    er = 1'b0;
                    el = 4'd0;
                    eb = (c == P * len + 1);
                    ed = eb;
                end
                chk("tl_led", 32'(bus.led), 32'(el));
                chk("tl_rd_en", 32'(bus.rd_en), 32'(er));
                chk("tl_busy", 32'(bus.busy), 32'(eb));
                chk("tl_done", 32'(bus.done), 32'(ed));
                if (er) chk("tl_rd_addr", 32'(bus.rd_addr), 32'(i[SEQ_AW-1:0]));
            end
            bus.start = (c == restart_at);
            if (c == restart_at) bus.len = (SEQ_AW+1)'(len + 3);
            bus.abort = (c == abort_at);
            bus.tick  = (tper == 1) || (c % tper == 0);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("queue_led_left", 32'(q_led.size()), 32'd0);
        chk("queue_addr_left", 32'(q_addr.size()), 32'd0);
        chk("extra_reads", 32'(extra_rd), 32'd0);
        chk("extra_flashes", 32'(extra_fl), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        bus.abort = 1'b0;
        bus.len   = 5'd2;
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;

        // Reset held with start and tick active
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_led", 32'(bus.led), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
            chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        end
        bus.start = 1'b0;
        reset     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
            chk("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
        end

        // Basic playback, memory {0,1}, len=2
        mem[0] = 2'd0;
        mem[1] = 2'd1;
        push_expect(2);
        play(2, 2 * P + 4, 1, 0, 0, 1'b1);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_done_cyc", 32'(done_cyc), 32'd15);

        // Slow timebase: tick every 8 cycles, single entry of value 3
        mem[0] = 2'd3;
        push_expect(1);
        play(1, 60, 8, 0, 0, 1'b0);
        chk("slow_first_lit", 32'(first_lit), 32'd3);
        chk("slow_last_lit", 32'(last_lit), 32'd24);
        chk("slow_lit_cnt", 32'(lit_cnt), 32'd22);
        chk("slow_done_cyc", 32'(done_cyc), 32'd41);
        chk("slow_done_cnt", 32'(done_cnt), 32'd1);

        // Zero-length start
        push_expect(0);
        play(0, 4, 1, 0, 0, 1'b1);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);
        chk("len0_lit_cnt", 32'(lit_cnt), 32'd0);

        // Full depth: every address once, no wrap
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
        push_expect(16);
        play(16, 16 * P + 4, 1, 0, 0, 1'b1);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        chk("full_lit_cnt", 32'(lit_cnt), 32'(16 * ON_T));

        // Abort during the second ON phase of a len=3 run
        mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;
        push_expect(2);
        play(3, 40, 1, P + 3, 0, 1'b0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_lit_cnt", 32'(lit_cnt), 32'(ON_T + 1));

        // Start while busy with a different len is ignored
        mem[0] = 2'd1; mem[1] = 2'd2;
        push_expect(2);
        play(2, 45, 1, 0, 4, 1'b1);
        chk("restart_done_cnt", 32'(done_cnt), 32'd1);
        chk("restart_done_cyc", 32'(done_cyc), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
